// File: rtl/rf_writeback_sequencer.sv
// rf_writeback_sequencer: serializes pipeline results (including dual-write LW.POI) onto the
// register file's single write bus through a 2-entry skid FIFO.  Rev 1.0
`default_nettype none

module rf_writeback_sequencer #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_rd_we,
  input  logic [DATA_W-1:0] in_rd_data,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic              in_rs1_we,
  input  logic [DATA_W-1:0] in_rs1_data,
  output logic              reg_write1,
  output logic              reg_write2,
  output logic [REG_AW-1:0] wb_rd,
  output logic [REG_AW-1:0] wb_rs1,
  output logic [DATA_W-1:0] Bus_W,
  output logic              busy
);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              rd_we;
    logic [DATA_W-1:0] rd_data;
    logic [REG_AW-1:0] rs1;
    logic              rs1_we;
    logic [DATA_W-1:0] rs1_data;
  } entry_t;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR1  = 2'd1;
  localparam logic [1:0] S_WR2  = 2'd2;

  entry_t              fifo_q [2];
  logic                wr_ptr_q;
  logic                rd_ptr_q;
  logic [1:0]          count_q;
  logic [1:0]          count_d;
  logic                ready_q;
  logic                ready_d;

  logic [1:0]          state_q;
  logic [1:0]          state_d;
  logic                pend_q;
  logic                pend_d;

  logic                wr1_q;
  logic                wr1_d;
  logic                wr2_q;
  logic                wr2_d;
  logic [REG_AW-1:0]   wb_rd_q;
  logic [REG_AW-1:0]   wb_rd_d;
  logic [REG_AW-1:0]   wb_rs1_q;
  logic [REG_AW-1:0]   wb_rs1_d;
  logic [DATA_W-1:0]   bus_q;
  logic [DATA_W-1:0]   bus_d;

  entry_t              in_entry;
  entry_t              head;
  logic                push_ok;
  logic                store;
  logic                pop;
  logic [REG_AW-1:0]   ld_addr;
  logic [DATA_W-1:0]   ld_data;

  // Canonicalize at the door: r0 is never written, and when both writes hit the same
  // register the base update wins.
  always_comb begin
    in_entry          = '0;
    in_entry.rd       = in_rd;
    in_entry.rd_data  = in_rd_data;
    in_entry.rs1      = in_rs1;
    in_entry.rs1_data = in_rs1_data;
    in_entry.rs1_we   = in_rs1_we && (in_rs1 != '0);
    in_entry.rd_we    = in_rd_we && (in_rd != '0) && !(in_entry.rs1_we && (in_rd == in_rs1));
  end

  // Results with no surviving write are accepted but never enter the FIFO.
  assign push_ok = in_valid && ready_q && (in_entry.rd_we || in_entry.rs1_we);
  assign head    = fifo_q[rd_ptr_q];

  // Next-state process.  An entry stays at the FIFO head until its last write is
  // loaded, so a pending WR2 always takes its address/data from the head.
  always_comb begin
    state_d = S_IDLE;
    pend_d  = 1'b0;
    pop     = 1'b0;
    store   = push_ok;
    ld_addr = head.rd;
    ld_data = head.rd_data;
    if ((state_q == S_WR1) && pend_q) begin
      state_d = S_WR2;
      pop     = 1'b1;
      ld_addr = head.rs1;
      ld_data = head.rs1_data;
    end else if (count_q != 2'd0) begin
      if (head.rd_we) begin
        state_d = S_WR1;
        pend_d  = head.rs1_we;
        pop     = !head.rs1_we;
      end else begin
        state_d = S_WR2;
        pop     = 1'b1;
        ld_addr = head.rs1;
        ld_data = head.rs1_data;
      end
    end else if (push_ok) begin
      // Bypass: only a dual-write entry needs storage to supply its second write.
      if (in_entry.rd_we) begin
        state_d = S_WR1;
        pend_d  = in_entry.rs1_we;
        store   = in_entry.rs1_we;
        ld_addr = in_entry.rd;
        ld_data = in_entry.rd_data;
      end else begin
        state_d = S_WR2;
        store   = 1'b0;
        ld_addr = in_entry.rs1;
        ld_data = in_entry.rs1_data;
      end
    end
  end

  assign count_d = count_q + 2'(store) - 2'(pop);
  assign ready_d = (count_d != 2'd2);

  // Output process: addresses and data hold their last value while idle.
  always_comb begin
    wr1_d    = (state_d == S_WR1);
    wr2_d    = (state_d == S_WR2);
    wb_rd_d  = wb_rd_q;
    wb_rs1_d = wb_rs1_q;
    bus_d    = bus_q;
    if (state_d == S_WR1) begin
      wb_rd_d = ld_addr;
      bus_d   = ld_data;
    end else if (state_d == S_WR2) begin
      wb_rs1_d = ld_addr;
      bus_d    = ld_data;
    end
  end

  // State register process.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pend_q   <= 1'b0;
      wr1_q    <= 1'b0;
      wr2_q    <= 1'b0;
      wb_rd_q  <= '0;
      wb_rs1_q <= '0;
      bus_q    <= '0;
      count_q  <= 2'd0;
      ready_q  <= 1'b1;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      wr1_q    <= wr1_d;
      wr2_q    <= wr2_d;
      wb_rd_q  <= wb_rd_d;
      wb_rs1_q <= wb_rs1_d;
      bus_q    <= bus_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      if (store) wr_ptr_q <= ~wr_ptr_q;
      if (pop)   rd_ptr_q <= ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else if (store) begin
      fifo_q[wr_ptr_q] <= in_entry;
    end
  end

  assign in_ready   = ready_q;
  assign reg_write1 = wr1_q;
  assign reg_write2 = wr2_q;
  assign wb_rd      = wb_rd_q;
  assign wb_rs1     = wb_rs1_q;
  assign Bus_W      = bus_q;
  assign busy       = (count_q != 2'd0) || (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_rf_writeback_sequencer.sv
// tb_rf_writeback_sequencer: directed stimulus with a queue-based scoreboard for the write bus.  Rev 1.0
`default_nettype none

module tb_rf_writeback_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_rd;
  logic        in_rd_we;
  logic [31:0] in_rd_data;
  logic [3:0]  in_rs1;
  logic        in_rs1_we;
  logic [31:0] in_rs1_data;
  logic        reg_write1;
  logic        reg_write2;
  logic [3:0]  wb_rd;
  logic [3:0]  wb_rs1;
  logic [31:0] Bus_W;
  logic        busy;

  rf_writeback_sequencer #(.DATA_W(32), .REG_AW(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_rd_we(in_rd_we), .in_rd_data(in_rd_data),
    .in_rs1(in_rs1), .in_rs1_we(in_rs1_we), .in_rs1_data(in_rs1_data),
    .reg_write1(reg_write1), .reg_write2(reg_write2),
    .wb_rd(wb_rd), .wb_rs1(wb_rs1), .Bus_W(Bus_W), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          kind;   // 0: Rd write, 1: Rs1 write
    logic [3:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   strobe_cnt = 0;
  bit   ready_low_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic push_exp(input bit kind, input logic [3:0] addr, input logic [31:0] data);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe cycle must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst) begin
      if (!in_ready) ready_low_seen = 1'b1;
      if (reg_write1 || reg_write2) begin
        strobe_cnt++;
        check("strobe_exclusive", 32'(reg_write1 & reg_write2), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_strobe: wr1=%b wr2=%b bus=0x%0h, expected no strobe",
                   reg_write1, reg_write2, Bus_W);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wb_kind", 32'(reg_write2), 32'(e.kind));
          check("wb_addr", 32'(e.kind ? wb_rs1 : wb_rd), 32'(e.addr));
          check("wb_data", Bus_W, e.data);
        end
      end
    end
  end

  // Called positioned 1 time unit after a rising edge; returns likewise after the transfer edge.
  task automatic send(input logic [3:0] rd, input bit rd_we, input logic [31:0] rd_d,
                      input logic [3:0] rs1, input bit rs1_we, input logic [31:0] rs1_d);
    int t = 0;
    in_valid    = 1'b1;
    in_rd       = rd;
    in_rd_we    = rd_we;
    in_rd_data  = rd_d;
    in_rs1      = rs1;
    in_rs1_we   = rs1_we;
    in_rs1_data = rs1_d;
    while (!in_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL send_timeout: in_ready=0, expected 1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((busy || exp_q.size() != 0) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_rd = '0; in_rd_we = 1'b0; in_rd_data = '0;
    in_rs1 = '0; in_rs1_we = 1'b0; in_rs1_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_reg_write1", 32'(reg_write1), 32'd0);
    check("rst_reg_write2", 32'(reg_write2), 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_wb_rs1", 32'(wb_rs1), 32'd0);
    check("rst_bus_w", Bus_W, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single Rd write: strobe directly after the accepting edge.
    push_exp(1'b0, 4'd5, 32'hDEADBEEF);
    send(4'd5, 1'b1, 32'hDEADBEEF, 4'd0, 1'b0, 32'h0);
    check("lat_wr1", 32'(reg_write1), 32'd1);
    check("lat_busy", 32'(busy), 32'd1);
    wait_idle("single");
    check("idle_hold_bus", Bus_W, 32'hDEADBEEF);
    check("idle_hold_rd", 32'(wb_rd), 32'd5);

    // LW.POI: Rd write then base write.
    push_exp(1'b0, 4'd3, 32'h11);
    push_exp(1'b1, 4'd7, 32'h104);
    send(4'd3, 1'b1, 32'h11, 4'd7, 1'b1, 32'h104);
    wait_idle("lwpoi");

    // Write to r0 is dropped entirely.
    s0 = strobe_cnt;
    send(4'd0, 1'b1, 32'h55, 4'd0, 1'b0, 32'h0);
    check("null_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk); #1;
    check("null_strobes", 32'(strobe_cnt - s0), 32'd0);

    // rd == rs1: only the base update survives.
    s0 = strobe_cnt;
    push_exp(1'b1, 4'd4, 32'h200);
    send(4'd4, 1'b1, 32'h100, 4'd4, 1'b1, 32'h200);
    wait_idle("same_reg");
    check("same_reg_strobes", 32'(strobe_cnt - s0), 32'd1);

    // Back-to-back LW.POI burst with in_valid held high.
    s0 = strobe_cnt;
    ready_low_seen = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      push_exp(1'b0, 4'(i), 32'hA0 + 32'(i));
      push_exp(1'b1, 4'(i + 8), 32'hB0 + 32'(i));
    end
    for (int i = 1; i <= 4; i++)
      send(4'(i), 1'b1, 32'hA0 + 32'(i), 4'(i + 8), 1'b1, 32'hB0 + 32'(i));
    wait_idle("burst");
    check("burst_strobes", 32'(strobe_cnt - s0), 32'd8);
    check("burst_ready_drop", 32'(ready_low_seen), 32'd1);

    // Reset while WR1 of a LW.POI is on the bus.
    push_exp(1'b0, 4'd9, 32'hAA);
    push_exp(1'b1, 4'd10, 32'hBB);
    send(4'd9, 1'b1, 32'hAA, 4'd10, 1'b1, 32'hBB);
    check("pre_rst_wr1", 32'(reg_write1), 32'd1);
    rst = 1'b1;
    #1;
    exp_q.delete();
    s0 = strobe_cnt;
    check("mid_rst_reg_write1", 32'(reg_write1), 32'd0);
    check("mid_rst_reg_write2", 32'(reg_write2), 32'd0);
    check("mid_rst_wb_rd", 32'(wb_rd), 32'd0);
    check("mid_rst_wb_rs1", 32'(wb_rs1), 32'd0);
    check("mid_rst_bus_w", Bus_W, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_strobes", 32'(strobe_cnt - s0), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
